// File: rtl/cos_th2_calc.sv
// Elbow-joint cosine for the SCARA IK chain: (x^2+y^2-l1^2-l2^2)/(2*l1*l2) in IEEE-754 double,
// sequenced over one shared multiplier, adder and divider, clamped to [-1, +1].

module fp_unit #(
   parameter int OP  = 0,
   parameter int LAT = 1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_in_ready,
   input  logic [63:0] i_a,
   input  logic [63:0] i_b,
   output logic        o_data_ready,
   output logic [63:0] o_result
);
   localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

   logic [3:0]  r_cnt;
   logic [63:0] w_res;

   function automatic logic f_nan(input logic [63:0] a);
      return (&a[62:52]) && (|a[51:0]);
   endfunction
   function automatic logic f_inf(input logic [63:0] a);
      return (&a[62:52]) && !(|a[51:0]);
   endfunction
   // Subnormals are flushed: a zero exponent counts as zero.
   function automatic logic f_zero(input logic [63:0] a);
      return (a[62:52] == 11'd0);
   endfunction

   function automatic logic [63:0] fpack(input logic s, input logic signed [13:0] e_in,
                                         input logic [52:0] m, input logic g, input logic st);
      logic [53:0]        mr;
      logic signed [13:0] e;
      e  = e_in;
      mr = {1'b0, m} + {53'd0, g & (st | m[0])};
      if (mr[53]) begin
         mr = mr >> 1;
         e  = e + 14'sd1;
      end
      if (e >= 14'sd2047)   fpack = {s, 11'h7FF, 52'd0};
      else if (e <= 14'sd0) fpack = {s, 63'd0};
      else                  fpack = {s, e[10:0], mr[51:0]};
   endfunction

   function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
      logic               s;
      logic [105:0]       p;
      logic signed [13:0] e;
      s = a[63] ^ b[63];
      p = {1'b1, a[51:0]} * {1'b1, b[51:0]};
      e = $signed({3'd0, a[62:52]}) + $signed({3'd0, b[62:52]}) - 14'sd1023;
      if (f_nan(a) || f_nan(b))      fmul = QNAN;
      else if (f_inf(a) || f_inf(b)) fmul = (f_zero(a) || f_zero(b)) ? QNAN : {s, 11'h7FF, 52'd0};
      else if (f_zero(a) || f_zero(b)) fmul = {s, 63'd0};
      else if (p[105])               fmul = fpack(s, e + 14'sd1, p[105:53], p[52], |p[51:0]);
      else                           fmul = fpack(s, e, p[104:52], p[51], |p[50:0]);
   endfunction

   function automatic logic [63:0] fadd(input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0]        a, b;
      logic [10:0]        d;
      logic [55:0]        wb;
      logic [56:0]        sum;
      logic signed [13:0] e;
      if (a_in[62:0] >= b_in[62:0]) begin a = a_in; b = b_in; end
      else                          begin a = b_in; b = a_in; end
      d  = a[62:52] - b[62:52];
      wb = {1'b1, b[51:0], 3'b000};
      // Three extra bits (guard, round, sticky) keep the aligned smaller operand exact enough for RNE.
      if (d > 11'd55)      wb = 56'd1;
      else if (d != 11'd0) wb = (wb >> d) | {55'd0, |(wb & ~({56{1'b1}} << d))};
      e = $signed({3'd0, a[62:52]});
      if (a[63] == b[63]) sum = {2'b01, a[51:0], 3'b000} + {1'b0, wb};
      else                sum = {2'b01, a[51:0], 3'b000} - {1'b0, wb};
      if (sum[56]) begin
         sum = {1'b0, sum[56:2], sum[1] | sum[0]};
         e   = e + 14'sd1;
      end else begin
         for (int i = 0; i < 56; i++)
            if (!sum[55] && sum != 57'd0) begin
               sum = sum << 1;
               e   = e - 14'sd1;
            end
      end
      if (f_nan(a_in) || f_nan(b_in))                        fadd = QNAN;
      else if (f_inf(a_in) && f_inf(b_in) && a_in[63] != b_in[63]) fadd = QNAN;
      else if (f_inf(a_in))                                  fadd = a_in;
      else if (f_inf(b_in))                                  fadd = b_in;
      else if (f_zero(a_in) && f_zero(b_in))                 fadd = {a_in[63] & b_in[63], 63'd0};
      else if (f_zero(a_in))                                 fadd = b_in;
      else if (f_zero(b_in))                                 fadd = a_in;
      else if (sum == 57'd0)                                 fadd = 64'd0;
      else                                                   fadd = fpack(a[63], e, sum[55:3], sum[2], |sum[1:0]);
   endfunction

   function automatic logic [63:0] fdiv(input logic [63:0] a, input logic [63:0] b);
      logic               s;
      logic [107:0]       num;
      logic [55:0]        q;
      logic               rem_nz;
      logic signed [13:0] e;
      s      = a[63] ^ b[63];
      num    = {1'b1, a[51:0], 55'd0};
      q      = 56'(num / {55'd0, 1'b1, b[51:0]});
      rem_nz = (num % {55'd0, 1'b1, b[51:0]}) != 108'd0;
      e      = $signed({3'd0, a[62:52]}) - $signed({3'd0, b[62:52]}) + 14'sd1023;
      if (f_nan(a) || f_nan(b))                                   fdiv = QNAN;
      else if ((f_inf(a) && f_inf(b)) || (f_zero(a) && f_zero(b))) fdiv = QNAN;
      else if (f_inf(a) || f_zero(b))                             fdiv = {s, 11'h7FF, 52'd0};
      else if (f_inf(b) || f_zero(a))                             fdiv = {s, 63'd0};
      else if (q[55])  fdiv = fpack(s, e, q[55:3], q[2], (|q[1:0]) | rem_nz);
      else             fdiv = fpack(s, e - 14'sd1, q[54:2], q[1], q[0] | rem_nz);
   endfunction

   always_comb begin
      case (OP)
         0:       w_res = fmul(i_a, i_b);
         1:       w_res = fadd(i_a, i_b);
         default: w_res = fdiv(i_a, i_b);
      endcase
   end

   // Result is taken on the first in_ready cycle; the counter only paces data_ready.
   always_ff @(posedge i_clk) begin
      if (i_reset)                               r_cnt <= 4'd0;
      else if (i_in_ready && r_cnt != 4'(LAT))   r_cnt <= r_cnt + 4'd1;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset && i_in_ready && r_cnt == 4'd0) o_result <= w_res;
   end

   assign o_data_ready = (r_cnt == 4'(LAT));
endmodule

module cos_th2_calc (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] x,
   input  logic [63:0] y,
   input  logic [63:0] l1,
   input  logic [63:0] l2,
   input  logic        enable,
   output logic        dataReady,
   output logic [63:0] cosTh2,
   output logic        outOfReach
);
   localparam int LAT_MUL = 4;
   localparam int LAT_ADD = 3;
   localparam int LAT_DIV = 8;
   localparam logic [63:0] POS_ONE = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] NEG_ONE = 64'hBFF0_0000_0000_0000;

   typedef enum logic [3:0] {
      S_IDLE, S_MUL_X, S_MUL_Y, S_MUL_L1, S_MUL_L2, S_MUL_L12,
      S_ADD_XY, S_ADD_L, S_SUB, S_DBL, S_DIV, S_CLAMP, S_DONE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_busy;
   logic [63:0] r_x, r_y, r_l1, r_l2, r_x2, r_y2, r_a2, r_b2, r_p, r_s, r_t, r_n, r_d, r_r, r_res;
   logic        r_oor;
   logic        w_is_mul, w_is_add, w_is_div, w_is_op, w_unit_done, w_capture;
   logic        w_mul_dr, w_add_dr, w_div_dr;
   logic [63:0] w_mul_a, w_mul_b, w_add_a, w_add_b, w_mul_res, w_add_res, w_div_res;
   logic [63:0] w_clamp_val;
   logic        w_clamp_oor;

   assign w_is_mul    = r_state inside {S_MUL_X, S_MUL_Y, S_MUL_L1, S_MUL_L2, S_MUL_L12};
   assign w_is_add    = r_state inside {S_ADD_XY, S_ADD_L, S_SUB, S_DBL};
   assign w_is_div    = (r_state == S_DIV);
   assign w_is_op     = w_is_mul | w_is_add | w_is_div;
   assign w_unit_done = (w_is_mul & w_mul_dr) | (w_is_add & w_add_dr) | (w_is_div & w_div_dr);
   assign w_capture   = r_busy & w_unit_done;

   // in_ready is low on the first cycle of every operation state, so each unit is reset between uses.
   fp_unit #(.OP(0), .LAT(LAT_MUL)) u_mul (
      .i_clk(clk), .i_reset(~(r_busy & w_is_mul)), .i_in_ready(r_busy & w_is_mul),
      .i_a(w_mul_a), .i_b(w_mul_b), .o_data_ready(w_mul_dr), .o_result(w_mul_res));
   fp_unit #(.OP(1), .LAT(LAT_ADD)) u_add (
      .i_clk(clk), .i_reset(~(r_busy & w_is_add)), .i_in_ready(r_busy & w_is_add),
      .i_a(w_add_a), .i_b(w_add_b), .o_data_ready(w_add_dr), .o_result(w_add_res));
   fp_unit #(.OP(2), .LAT(LAT_DIV)) u_div (
      .i_clk(clk), .i_reset(~(r_busy & w_is_div)), .i_in_ready(r_busy & w_is_div),
      .i_a(r_n), .i_b(r_d), .o_data_ready(w_div_dr), .o_result(w_div_res));

   always_comb begin
      w_mul_a = r_x;
      w_mul_b = r_x;
      w_add_a = r_x2;
      w_add_b = r_y2;
      case (r_state)
         S_MUL_Y:   begin w_mul_a = r_y;  w_mul_b = r_y;  end
         S_MUL_L1:  begin w_mul_a = r_l1; w_mul_b = r_l1; end
         S_MUL_L2:  begin w_mul_a = r_l2; w_mul_b = r_l2; end
         S_MUL_L12: begin w_mul_a = r_l1; w_mul_b = r_l2; end
         S_ADD_L:   begin w_add_a = r_a2; w_add_b = r_b2; end
         S_SUB:     begin w_add_a = r_s;  w_add_b = {~r_t[63], r_t[62:0]}; end
         S_DBL:     begin w_add_a = r_p;  w_add_b = r_p;  end
         default:   ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (enable)    w_state_nxt = S_MUL_X;
         S_MUL_X:   if (w_capture) w_state_nxt = S_MUL_Y;
         S_MUL_Y:   if (w_capture) w_state_nxt = S_MUL_L1;
         S_MUL_L1:  if (w_capture) w_state_nxt = S_MUL_L2;
         S_MUL_L2:  if (w_capture) w_state_nxt = S_MUL_L12;
         S_MUL_L12: if (w_capture) w_state_nxt = S_ADD_XY;
         S_ADD_XY:  if (w_capture) w_state_nxt = S_ADD_L;
         S_ADD_L:   if (w_capture) w_state_nxt = S_SUB;
         S_SUB:     if (w_capture) w_state_nxt = S_DBL;
         S_DBL:     if (w_capture) w_state_nxt = S_DIV;
         S_DIV:     if (w_capture) w_state_nxt = S_CLAMP;
         S_CLAMP:                  w_state_nxt = S_DONE;
         default:                  w_state_nxt = S_IDLE;
      endcase
   end

   // NaN/Inf and |r| > 1 both saturate by sign; exactly +/-1.0 passes through unflagged.
   always_comb begin
      w_clamp_val = r_r;
      w_clamp_oor = 1'b0;
      if ((&r_r[62:52]) || (r_r[62:0] > 63'h3FF0_0000_0000_0000)) begin
         w_clamp_val = r_r[63] ? NEG_ONE : POS_ONE;
         w_clamp_oor = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_busy     <= 1'b0;
         dataReady  <= 1'b0;
         cosTh2     <= 64'd0;
         outOfReach <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_busy  <= w_is_op & ~(r_busy & w_unit_done);
         if (r_state == S_IDLE && enable) begin
            dataReady  <= 1'b0;
            outOfReach <= 1'b0;
         end
         if (r_state == S_DONE) begin
            dataReady  <= 1'b1;
            cosTh2     <= r_res;
            outOfReach <= r_oor;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && enable) begin
         r_x  <= x;
         r_y  <= y;
         r_l1 <= l1;
         r_l2 <= l2;
      end
      if (w_capture) begin
         case (r_state)
            S_MUL_X:   r_x2 <= w_mul_res;
            S_MUL_Y:   r_y2 <= w_mul_res;
            S_MUL_L1:  r_a2 <= w_mul_res;
            S_MUL_L2:  r_b2 <= w_mul_res;
            S_MUL_L12: r_p  <= w_mul_res;
            S_ADD_XY:  r_s  <= w_add_res;
            S_ADD_L:   r_t  <= w_add_res;
            S_SUB:     r_n  <= w_add_res;
            S_DBL:     r_d  <= w_add_res;
            S_DIV:     r_r  <= w_div_res;
            default:   ;
         endcase
      end
      if (r_state == S_CLAMP) begin
         r_res <= w_clamp_val;
         r_oor <= w_clamp_oor;
      end
   end
endmodule

// File: tb/tb_cos_th2_calc.sv
// Scoreboard bench for cos_th2_calc: directed vectors push expected results, a monitor checks each
// dataReady rising edge for value, flag and latency.

module tb_cos_th2_calc;
   // 5*(Lm+2) + 4*(La+2) + (Ld+2) + 2 with Lm=4, La=3, Ld=8
   localparam int LAT = 62;

   localparam logic [63:0] D0   = 64'h0000_0000_0000_0000;
   localparam logic [63:0] D1   = 64'h3FF0_0000_0000_0000;
   localparam logic [63:0] DM1  = 64'hBFF0_0000_0000_0000;
   localparam logic [63:0] D2   = 64'h4000_0000_0000_0000;
   localparam logic [63:0] D3   = 64'h4008_0000_0000_0000;
   localparam logic [63:0] DH   = 64'h3FE0_0000_0000_0000;
   localparam logic [63:0] D1P5 = 64'h3FF8_0000_0000_0000;
   localparam logic [63:0] DQ   = 64'h3FD0_0000_0000_0000;
   localparam logic [63:0] DMT  = 64'hBFD5_5555_5555_5555;

   typedef struct {
      logic [63:0] cos;
      logic        oor;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] x, y, l1, l2;
   logic        enable;
   logic        dataReady;
   logic [63:0] cosTh2;
   logic        outOfReach;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   logic [63:0] tv [0:7][0:4];
   logic        tv_oor [0:7];

   cos_th2_calc dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .l1(l1), .l2(l2), .enable(enable),
      .dataReady(dataReady), .cosTh2(cosTh2), .outOfReach(outOfReach));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [63:0] ix, input logic [63:0] iy, input logic [63:0] il1,
                        input logic [63:0] il2, input logic [63:0] ec, input logic eo);
      exp_t e;
      x = ix; y = iy; l1 = il1; l2 = il2;
      enable = 1'b1;
      e.cos = ec; e.oor = eo; e.acc = cyc + 1;
      sb_q.push_back(e);
      @(negedge clk);
      enable = 1'b0;
      chk("dr_fall_after_accept", {63'd0, dataReady}, 64'd0);
   endtask

   task automatic wait_done();
      int k = 0;
      while (!dataReady && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", {63'd0, dataReady}, 64'd1);
   endtask

   initial begin : monitor
      logic prev = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (dataReady && !prev) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got %h with no pending request", cosTh2);
            end else begin
               e = sb_q.pop_front();
               chk("cosTh2", cosTh2, e.cos);
               chk("outOfReach", {63'd0, outOfReach}, {63'd0, e.oor});
               chk("latency", 64'(cyc - e.acc), 64'(LAT));
            end
         end
         prev = dataReady;
      end
   end

   initial begin : stimulus
      tv[0] = '{D1,   D1, D1,   D1, D0};   tv_oor[0] = 1'b0;
      tv[1] = '{D2,   D0, D1,   D1, D1};   tv_oor[1] = 1'b0;
      tv[2] = '{D0,   D0, D1,   D1, DM1};  tv_oor[2] = 1'b0;
      tv[3] = '{D3,   D0, D1,   D1, D1};   tv_oor[3] = 1'b1;
      tv[4] = '{DH,   D0, D2,   D1, DM1};  tv_oor[4] = 1'b1;
      tv[5] = '{D1,   D1, D1,   D0, D1};   tv_oor[5] = 1'b1;
      tv[6] = '{D1P5, DH, D1,   D1, DQ};   tv_oor[6] = 1'b0;
      tv[7] = '{D1,   D1, D1P5, DH, DMT};  tv_oor[7] = 1'b0;

      reset = 1'b0; enable = 1'b0;
      x = D0; y = D0; l1 = D0; l2 = D0;
      repeat (3) @(negedge clk);
      chk("reset_dataReady", {63'd0, dataReady}, 64'd0);
      chk("reset_cosTh2", cosTh2, 64'd0);
      chk("reset_outOfReach", {63'd0, outOfReach}, 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // back-to-back: each request is issued in the first IDLE cycle after the previous result
      for (int i = 0; i < 8; i++) begin
         issue(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv_oor[i]);
         wait_done();
      end

      // inputs changed and enable toggled mid-computation must not disturb the latched request
      issue(D3, D0, D1, D1, D1, 1'b1);
      repeat (10) @(negedge clk);
      x = D1; y = D1; l1 = D2; l2 = DH; enable = 1'b1;
      repeat (3) @(negedge clk);
      enable = 1'b0;
      wait_done();
      repeat (10) @(negedge clk);
      chk("hold_dataReady", {63'd0, dataReady}, 64'd1);
      chk("hold_cosTh2", cosTh2, D1);
      chk("hold_outOfReach", {63'd0, outOfReach}, 64'd1);

      // abort during DIV: outputs must drop asynchronously, before the next clock edge
      issue(D1P5, DH, D1, D1, DQ, 1'b0);
      repeat (52) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      chk("abort_dataReady", {63'd0, dataReady}, 64'd0);
      chk("abort_cosTh2", cosTh2, 64'd0);
      chk("abort_outOfReach", {63'd0, outOfReach}, 64'd0);
      void'(sb_q.pop_back());
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (80) @(negedge clk);
      chk("abort_no_result", {63'd0, dataReady}, 64'd0);

      issue(D1, D1, D1P5, DH, DMT, 1'b0);
      wait_done();
      issue(D2, D0, D1, D1, D1, 1'b0);
      wait_done();

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cos_th2_calc.md
# cos_th2_calc

Computes the elbow-joint cosine for the SCARA inverse-kinematics chain, cosTh2 = (x² + y² − l1² − l2²) / (2·l1·l2), in IEEE-754 double precision. It sits directly upstream of the K1 stage (K1 = l1 + l2·cosTh2), and its cosTh2/dataReady pair feeds that stage's CosTh2/enable. It time-shares one DoubleMultiply, one DoubleAdder and one DoubleDivide under a sequencing FSM. It clamps unreachable targets to ±1.0 and flags them.

## Interface
- Parameters: none.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- x  in  64  target X, double.
- y  in  64  target Y, double.
- l1  in  64  link 1 length, double.
- l2  in  64  link 2 length, double.
- enable  in  1  start request; sampled only in IDLE.
- dataReady  out  1  result valid; held until the next accepted enable.
- cosTh2  out  64  result, double, always within [−1.0, +1.0] or exactly ±1.0 when clamped.
- outOfReach  out  1  set when the raw quotient was outside [−1, 1] or was NaN/Inf; valid while dataReady = 1.

## Operation
- Reset values: dataReady = 0, cosTh2 = 64'h0, outOfReach = 0, state = IDLE, all unit in_ready = 0 (units held in reset).
- IDLE: on enable = 1, latch x, y, l1, l2 into internal registers, clear dataReady and outOfReach, and go to MUL_X.
- Operation states run in this fixed order:
  - MUL_X: x·x → x2
  - MUL_Y: y·y → y2
  - MUL_L1: l1·l1 → a2
  - MUL_L2: l2·l2 → b2
  - MUL_L12: l1·l2 → p
  - ADD_XY: x2 + y2 → s
  - ADD_L: a2 + b2 → t
  - SUB: s + (t with bit 63 inverted) → n
  - DBL: p + p → d
  - DIV: n / d → r
  - CLAMP
  - DONE → IDLE
- Each unit's reset input is driven by ~in_ready. in_ready is deasserted for at least one cycle between consecutive uses of the same unit, so the unit always restarts clean.
- Operand muxes are selected by state. Unit outputs are captured into the named register on the cycle data_ready is seen.
- CLAMP rules, applied to r:
  - If r[62:52] = 11'h7FF (NaN or Inf): cosTh2 = r[63] ? 64'hBFF0000000000000 : 64'h3FF0000000000000, and outOfReach = 1. NaN with sign 0 maps to +1.0.
  - Else if r[62:0] > 63'h3FF0000000000000: same sign-based ±1.0, and outOfReach = 1.
  - Else cosTh2 = r and outOfReach = 0. Exactly ±1.0 is not flagged.
- DONE: set dataReady = 1 and return to IDLE. cosTh2, outOfReach and dataReady then hold until the next enable is accepted.
- enable while not in IDLE is ignored. Input changes after latching have no effect on the running computation.
- Reset asserted mid-operation aborts immediately to the reset values. No partial result is ever presented.

## Timing
- Each operation state takes exactly L_unit + 2 cycles:
  - 1 cycle to assert in_ready with operands stable;
  - L_unit cycles until the unit's data_ready;
  - 1 cycle to capture the result and drop in_ready.
- Total latency from the enable-accept edge to the dataReady rising edge = 5·(Lm+2) + 4·(La+2) + (Ld+2) + 2 cycles, where the trailing 2 covers CLAMP and DONE. Lm, La and Ld are the fixed multiplier, adder and divider latencies.
- dataReady rises in the same cycle cosTh2/outOfReach take their final values. It falls on the cycle after enable is accepted.
- Back-to-back: enable may be asserted in the first IDLE cycle after DONE. It is accepted with no dead cycle.

## Test plan
- x=1.0 (3FF0…), y=1.0, l1=1.0, l2=1.0 → cosTh2 = 64'h0000000000000000, outOfReach=0, dataReady after exactly the computed latency.
- x=2.0 (4000…), y=0, l1=l2=1.0 → cosTh2 = 64'h3FF0000000000000, outOfReach=0 (boundary not flagged); x=0, y=0, l1=l2=1.0 → 64'hBFF0000000000000, outOfReach=0.
- x=3.0 (4008…), y=0, l1=l2=1.0 (raw 3.5) → cosTh2 = 64'h3FF0000000000000, outOfReach=1; x=0.5 (3FE0…), y=0, l1=2.0, l2=1.0 (raw −1.1875) → 64'hBFF0000000000000, outOfReach=1.
- l2=0 with x=y=l1=1.0 (divide by zero → Inf/NaN) → cosTh2 = ±1.0 per sign rule, outOfReach=1, no hang.
- Reset pulsed low during DIV → all outputs return to reset values asynchronously; the next enable produces the correct result with full latency.
- enable toggled and inputs changed mid-computation → ignored; result matches the originally latched inputs; dataReady held high across idle cycles until the next enable.
